csr_trap_file: RTL and testbench
================================

// Module: csr_trap_file
// PURPOSE
//  Machine-mode CSR register file and trap sequencer, on the responder side of the decode-stage CSR
//  decoder. Serves combinational CSR reads to decode (old value for csrrw/csrrs/csrrc). Commits CSR
//  writes at writeback. Turns ecall/mret signals arriving in execute into a registered one-cycle PC
//  redirect with pipeline flush, and keeps the 64-bit mcycle counter.
// PARAMETERS
//  RESET_MTVEC  32'h0000_0100  mtvec value after reset; low 2 bits forced to 0 (direct mode only)
//  ECALL_CAUSE  32'd11         value written to mcause on ecall (environment call from M-mode)
// PORTS
//  i_clk              in   1   clock, rising edge
//  i_rst              in   1   asynchronous, active-high reset
//  i_csr_addr_d       in   12  CSR address for decode-stage read (instruction imm field)
//  o_csr_data_d       out  32  current CSR value, combinational, with writeback bypass
//  i_csr_reg_write_w  in   1   writeback CSR write enable
//  i_csr_rd_w         in   12  writeback CSR address
//  i_new_csr_w        in   32  writeback CSR data
//  i_ecall_e          in   1   ecall in execute stage
//  i_mret_e           in   1   mret in execute stage
//  i_pc_e             in   32  PC of the execute-stage instruction
//  o_redirect         out  1   one-cycle pulse: fetch takes o_redirect_pc, pipeline flushes F/D/E
//  o_redirect_pc      out  32  trap target: mtvec on ecall, mepc on mret; 0 when o_redirect=0
//  o_mie              out  1   mstatus.MIE, for the interrupt logic
// BEHAVIOUR
//  Implemented CSRs and reset values:
//   mstatus 0x300 = 0; only bit 3 (MIE) and bit 7 (MPIE) are writable, all other bits read 0
//   mie 0x304 = 0; mtvec 0x305 = RESET_MTVEC&~3; mscratch 0x340 = 0; mepc 0x341 = 0, bits[1:0] read 0
//   mcause 0x342 = 0; mtval 0x343 = 0; mcycle 0xB00 / mcycleh 0xB80 = 0
//  Any other address reads 0; writes to it are ignored, with no error.
//  Read: o_csr_data_d is combinational from i_csr_addr_d. If i_csr_reg_write_w=1 and
//   i_csr_rd_w==i_csr_addr_d, o_csr_data_d returns i_new_csr_w after the field masks are applied.
//  Write: on a rising edge with i_csr_reg_write_w=1, the addressed CSR takes i_new_csr_w (masked).
//  mcycle: the 64-bit {mcycleh,mcycle} increments by 1 every cycle and carries from low to high.
//   A writeback write to either half replaces that half's increment on that edge; the other half
//   does not receive a carry on that edge.
//  FSM, 2 states:
//   IDLE: o_redirect=0.
//    i_ecall_e=1 -> at the edge: mepc<=i_pc_e&~3, mcause<=ECALL_CAUSE, MPIE<=MIE, MIE<=0;
//     latch target=mtvec; go to REDIRECT.
//    else i_mret_e=1 -> at the edge: MIE<=MPIE, MPIE<=1; latch target=mepc; go to REDIRECT.
//    If both are asserted, ecall wins.
//   REDIRECT (exactly 1 cycle): o_redirect=1, o_redirect_pc=latched target; always returns to IDLE.
//    i_ecall_e and i_mret_e are ignored here, because that instruction is being flushed.
//  Latency: ecall/mret seen at edge N -> o_redirect high for the cycle after edge N, low after N+1.
//  Simultaneous trap and writeback on the same edge: the trap update wins for the trap-owned fields
//   (mepc, mcause, mstatus.MIE/MPIE). Writeback to any other CSR still commits. The trap is younger
//   in program order, so its update is the later one.
//  The mtvec latched for the redirect includes a writeback to mtvec on the same edge, i.e. the
//   bypassed value.
//  Reset mid-REDIRECT: go to IDLE immediately; o_redirect=0, o_redirect_pc=0; all CSRs to reset values.
//  Reset values of outputs: o_redirect=0, o_redirect_pc=0, o_mie=0; o_csr_data_d follows the reset CSRs.
// TESTING
//  1 Reset, then read 0x305 -> 32'h0000_0100; read 0x342 -> 0; read 0x7C0 (unimplemented) -> 0.
//  2 WB write 0x340=32'hDEAD_BEEF while decode reads 0x340 -> same cycle 32'hDEAD_BEEF (bypass);
//    next cycle still 32'hDEAD_BEEF.
//  3 MIE=1, ecall_e with pc_e=32'h0000_0048 -> next cycle o_redirect=1, o_redirect_pc=32'h100;
//    then mepc=32'h48, mcause=11, MPIE=1, MIE=0; o_redirect=0 one cycle later.
//  4 After 3, mret_e -> redirect to 32'h48; MIE=1, MPIE=1; an ecall_e held during REDIRECT
//    produces no second redirect.
//  5 Write mcycle=32'hFFFF_FFFF, mcycleh=0 -> one cycle later {mcycleh,mcycle}=64'h1_0000_0000.
//  6 ecall_e and WB write mepc=32'h200 on the same edge -> mepc=i_pc_e. Separately: assert reset
//    during REDIRECT -> o_redirect drops immediately, mtvec reads 32'h100.

Source files
------------

// File: rtl/csr_trap_file.sv
// Machine-mode CSR register file with writeback bypass, a 64-bit cycle counter and a
// two-state ecall/mret sequencer that issues a registered one-cycle PC redirect.
module csr_trap_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_csr_addr_d,
    output logic [31:0] o_csr_data_d,
    input  logic        i_csr_reg_write_w,
    input  logic [11:0] i_csr_rd_w,
    input  logic [31:0] i_new_csr_w,
    input  logic        i_ecall_e,
    input  logic        i_mret_e,
    input  logic [31:0] i_pc_e,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_mie
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    // Writable bits per CSR; unimplemented addresses have no writable bits, so they read 0.
    function automatic logic [31:0] field_mask(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS:                          field_mask = 32'h0000_0088;
            ADDR_MTVEC, ADDR_MEPC:                 field_mask = 32'hFFFF_FFFC;
            ADDR_MIE, ADDR_MSCRATCH, ADDR_MCAUSE,
            ADDR_MTVAL, ADDR_MCYCLE, ADDR_MCYCLEH: field_mask = 32'hFFFF_FFFF;
            default:                               field_mask = 32'h0000_0000;
        endcase
    endfunction

    logic [0:0]  state;
    logic [31:0] target;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_reg;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;

    logic [31:0] wb_data;
    logic        wb_mstatus, wb_mie, wb_mtvec, wb_mscratch, wb_mepc;
    logic        wb_mcause, wb_mtval, wb_mcycle, wb_mcycleh;
    logic [31:0] stored_data;
    logic        trap_ecall;
    logic        trap_mret;
    logic        post_mie;
    logic        post_mpie;
    logic [31:0] post_mtvec;
    logic [31:0] post_mepc;
    logic [31:0] post_mcause;
    logic [31:0] mcycle_lo_next;
    logic [31:0] mcycle_hi_next;

    assign wb_data     = i_new_csr_w & field_mask(i_csr_rd_w);
    assign wb_mstatus  = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MSTATUS);
    assign wb_mie      = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MIE);
    assign wb_mtvec    = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MTVEC);
    assign wb_mscratch = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MSCRATCH);
    assign wb_mepc     = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MEPC);
    assign wb_mcause   = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MCAUSE);
    assign wb_mtval    = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MTVAL);
    assign wb_mcycle   = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MCYCLE);
    assign wb_mcycleh  = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MCYCLEH);

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        stored_data = 32'h0;
        case (i_csr_addr_d)
            ADDR_MSTATUS:  stored_data = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
            ADDR_MIE:      stored_data = mie_reg;
            ADDR_MTVEC:    stored_data = mtvec;
            ADDR_MSCRATCH: stored_data = mscratch;
            ADDR_MEPC:     stored_data = mepc;
            ADDR_MCAUSE:   stored_data = mcause;
            ADDR_MTVAL:    stored_data = mtval;
            ADDR_MCYCLE:   stored_data = mcycle[31:0];
            ADDR_MCYCLEH:  stored_data = mcycle[63:32];
            default:       stored_data = 32'h0;
        endcase
    end

    assign o_csr_data_d = (i_csr_reg_write_w && (i_csr_rd_w == i_csr_addr_d)) ? wb_data : stored_data;

    // The trap sees the CSR state as it stands after the older writeback instruction commits.
    assign post_mie    = wb_mstatus ? wb_data[3] : mstatus_mie;
    assign post_mpie   = wb_mstatus ? wb_data[7] : mstatus_mpie;
    assign post_mtvec  = wb_mtvec   ? wb_data    : mtvec;
    assign post_mepc   = wb_mepc    ? wb_data    : mepc;
    assign post_mcause = wb_mcause  ? wb_data    : mcause;

    assign trap_ecall = (state == IDLE) && i_ecall_e;
    assign trap_mret  = (state == IDLE) && !i_ecall_e && i_mret_e;

    // A write to one half replaces its increment and blocks the carry into the other half.
    assign mcycle_lo_next = wb_mcycle  ? wb_data : mcycle[31:0] + 32'd1;
    assign mcycle_hi_next = wb_mcycleh ? wb_data
                          : wb_mcycle  ? mcycle[63:32]
                          : mcycle[63:32] + {31'h0, &mcycle[31:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            target       <= 32'h0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= 32'h0;
            mtvec        <= RESET_MTVEC & 32'hFFFF_FFFC;
            mscratch     <= 32'h0;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            mtval        <= 32'h0;
            mcycle       <= 64'h0;
        end else begin
            if (wb_mie)      mie_reg  <= wb_data;
            if (wb_mtvec)    mtvec    <= wb_data;
            if (wb_mscratch) mscratch <= wb_data;
            if (wb_mtval)    mtval    <= wb_data;
            mcycle <= {mcycle_hi_next, mcycle_lo_next};

            mepc         <= trap_ecall ? (i_pc_e & 32'hFFFF_FFFC) : post_mepc;
            mcause       <= trap_ecall ? ECALL_CAUSE : post_mcause;
            mstatus_mie  <= trap_ecall ? 1'b0 : (trap_mret ? post_mpie : post_mie);
            mstatus_mpie <= trap_ecall ? post_mie : (trap_mret ? 1'b1 : post_mpie);

            if (trap_ecall)     target <= post_mtvec;
            else if (trap_mret) target <= post_mepc;

            state <= (trap_ecall || trap_mret) ? REDIRECT : IDLE;
        end
    end

    assign o_redirect    = (state == REDIRECT);
    assign o_redirect_pc = o_redirect ? target : 32'h0;
    assign o_mie         = mstatus_mie;

endmodule

// File: tb/tb_csr_trap_file.sv
// Directed bench for csr_trap_file: a vector table for reads/writes/bypass, then hand-written
// sequences for ecall, mret, mcycle carry, trap-vs-writeback priority and reset mid-redirect.
module tb_csr_trap_file;

    logic        clk;
    logic        rst;
    logic [11:0] csr_addr_d;
    logic [31:0] csr_data_d;
    logic        csr_reg_write_w;
    logic [11:0] csr_rd_w;
    logic [31:0] new_csr_w;
    logic        ecall_e;
    logic        mret_e;
    logic [31:0] pc_e;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mie;

    int checks = 0;
    int errors = 0;

    csr_trap_file dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_csr_addr_d      (csr_addr_d),
        .o_csr_data_d      (csr_data_d),
        .i_csr_reg_write_w (csr_reg_write_w),
        .i_csr_rd_w        (csr_rd_w),
        .i_new_csr_w       (new_csr_w),
        .i_ecall_e         (ecall_e),
        .i_mret_e          (mret_e),
        .i_pc_e            (pc_e),
        .o_redirect        (redirect),
        .o_redirect_pc     (redirect_pc),
        .o_mie             (mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [11:0] rd;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mie;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] expected);
        csr_addr_d = addr;
        #1;
        check(name, csr_data_d, expected);
    endtask

    task automatic quiet();
        csr_reg_write_w = 1'b0;
        csr_rd_w        = 12'h0;
        new_csr_w       = 32'h0;
        ecall_e         = 1'b0;
        mret_e          = 1'b0;
        pc_e            = 32'h0;
    endtask

    initial begin
        vecs[0]  = '{12'h305, 1'b0, 12'h000, 32'h0,         32'h0000_0100, 1'b0};
        vecs[1]  = '{12'h342, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{12'h7C0, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[3]  = '{12'h300, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[4]  = '{12'h340, 1'b1, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{12'h340, 1'b0, 12'h000, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{12'h300, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088, 1'b0};
        vecs[7]  = '{12'h300, 1'b0, 12'h000, 32'h0,         32'h0000_0088, 1'b1};
        vecs[8]  = '{12'h305, 1'b1, 12'h305, 32'h0000_0203, 32'h0000_0200, 1'b1};
        vecs[9]  = '{12'h305, 1'b0, 12'h000, 32'h0,         32'h0000_0200, 1'b1};
        vecs[10] = '{12'h7C0, 1'b1, 12'h7C0, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[11] = '{12'h7C0, 1'b0, 12'h000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[12] = '{12'h341, 1'b1, 12'h341, 32'h0000_0123, 32'h0000_0120, 1'b1};
        vecs[13] = '{12'h300, 1'b1, 12'h300, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{12'h305, 1'b1, 12'h305, 32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[15] = '{12'h304, 1'b1, 12'h304, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
        vecs[16] = '{12'h340, 1'b1, 12'h343, 32'hCAFE_0001, 32'hDEAD_BEEF, 1'b0};
        vecs[17] = '{12'h343, 1'b0, 12'h000, 32'h0,         32'hCAFE_0001, 1'b0};

        rst = 1'b1;
        csr_addr_d = 12'h0;
        quiet();
        repeat (2) @(negedge clk);
        #1;
        check("reset redirect", {31'h0, redirect}, 32'h0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset mie", {31'h0, mie}, 32'h0);
        rst = 1'b0;

        // Table: drive between edges, check combinationally before the committing edge.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            csr_reg_write_w = vecs[i].we;
            csr_rd_w        = vecs[i].rd;
            new_csr_w       = vecs[i].wdata;
            csr_addr_d      = vecs[i].addr;
            #1;
            check($sformatf("vec%0d data", i), csr_data_d, vecs[i].exp_data);
            check($sformatf("vec%0d mie", i), {31'h0, mie}, {31'h0, vecs[i].exp_mie});
            check($sformatf("vec%0d redirect", i), {31'h0, redirect}, 32'h0);
        end

        // ecall with MIE=1
        @(negedge clk);
        quiet();
        csr_reg_write_w = 1'b1; csr_rd_w = 12'h300; new_csr_w = 32'h0000_0008;
        @(negedge clk);
        quiet();
        ecall_e = 1'b1; pc_e = 32'h0000_0048;
        #1;
        check("pre-ecall mie", {31'h0, mie}, 32'h1);
        @(negedge clk);
        quiet();
        #1;
        check("ecall redirect", {31'h0, redirect}, 32'h1);
        check("ecall redirect_pc", redirect_pc, 32'h0000_0100);
        read_check("ecall mepc", 12'h341, 32'h0000_0048);
        read_check("ecall mcause", 12'h342, 32'd11);
        read_check("ecall mstatus", 12'h300, 32'h0000_0080);
        check("ecall mie", {31'h0, mie}, 32'h0);
        @(negedge clk);
        #1;
        check("ecall redirect end", {31'h0, redirect}, 32'h0);
        check("ecall redirect_pc end", redirect_pc, 32'h0);

        // mret, with an ecall held only during the REDIRECT cycle
        mret_e = 1'b1;
        @(negedge clk);
        quiet();
        ecall_e = 1'b1; pc_e = 32'h0000_0400;
        #1;
        check("mret redirect", {31'h0, redirect}, 32'h1);
        check("mret redirect_pc", redirect_pc, 32'h0000_0048);
        read_check("mret mstatus", 12'h300, 32'h0000_0088);
        check("mret mie", {31'h0, mie}, 32'h1);
        @(negedge clk);
        quiet();
        #1;
        check("ignored ecall redirect", {31'h0, redirect}, 32'h0);
        read_check("ignored ecall mepc", 12'h341, 32'h0000_0048);
        read_check("ignored ecall mstatus", 12'h300, 32'h0000_0088);
        @(negedge clk);
        #1;
        check("ignored ecall redirect+1", {31'h0, redirect}, 32'h0);

        // mcycle carry from low to high half
        csr_reg_write_w = 1'b1; csr_rd_w = 12'hB80; new_csr_w = 32'h0;
        @(negedge clk);
        csr_rd_w = 12'hB00; new_csr_w = 32'hFFFF_FFFF;
        @(negedge clk);
        quiet();
        read_check("mcycle written", 12'hB00, 32'hFFFF_FFFF);
        read_check("mcycleh written", 12'hB80, 32'h0);
        @(negedge clk);
        read_check("mcycle wrapped", 12'hB00, 32'h0);
        read_check("mcycleh carry", 12'hB80, 32'h1);

        // ecall and writeback to mepc on the same edge: trap wins
        @(negedge clk);
        ecall_e = 1'b1; pc_e = 32'h0000_0064;
        csr_reg_write_w = 1'b1; csr_rd_w = 12'h341; new_csr_w = 32'h0000_0200;
        @(negedge clk);
        quiet();
        #1;
        check("wb+ecall redirect_pc", redirect_pc, 32'h0000_0100);
        read_check("wb+ecall mepc", 12'h341, 32'h0000_0064);
        @(negedge clk);

        // ecall with a same-edge mtvec write uses the new mtvec, then reset mid-redirect
        ecall_e = 1'b1; pc_e = 32'h0000_0080;
        csr_reg_write_w = 1'b1; csr_rd_w = 12'h305; new_csr_w = 32'h0000_0301;
        @(negedge clk);
        quiet();
        #1;
        check("mtvec bypass redirect", {31'h0, redirect}, 32'h1);
        check("mtvec bypass redirect_pc", redirect_pc, 32'h0000_0300);
        read_check("mtvec written", 12'h305, 32'h0000_0300);
        rst = 1'b1;
        #1;
        check("reset mid redirect", {31'h0, redirect}, 32'h0);
        check("reset mid redirect_pc", redirect_pc, 32'h0);
        read_check("reset mtvec", 12'h305, 32'h0000_0100);
        read_check("reset mscratch", 12'h340, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post-reset redirect", {31'h0, redirect}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
